bumpy_hit_detect: RTL and testbench

Per-frame collision classifier upstream of Bumpy's motion stage. Watches the pixel scan, finds where Bumpy's drawing request overlaps brick, jump-brick or border drawing requests, and records which sprite edge(s) the overlap touched. Commits the result once per frame so the motion stage sees stable `collision`, `jumpCollision` and `HitEdgeCode` for the whole following frame.

---
 rtl/bumpy_hit_detect_if.sv | 29 ++
 rtl/bumpy_hit_detect.sv | 146 ++++++++++++++
 tb/tb_bumpy_hit_detect.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bumpy_hit_detect_if.sv
// Pixel-scan / collision-result bundle between the video pipeline and bumpy_hit_detect.
// The master drives the scan and drawing requests; the slave returns the committed result.
interface bumpy_hit_detect_if;
  logic               startOfFrame;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               bumpyDR;
  logic               brickDR;
  logic               jumpBrickDR;
  logic               borderDR;
  logic               EndGame;
  logic               collision;
  logic               jumpCollision;
  logic [3:0]         HitEdgeCode;

  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           bumpyDR, brickDR, jumpBrickDR, borderDR, EndGame,
    input  collision, jumpCollision, HitEdgeCode
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           bumpyDR, brickDR, jumpBrickDR, borderDR, EndGame,
    output collision, jumpCollision, HitEdgeCode
  );
endinterface

// File: rtl/bumpy_hit_detect.sv
// Per-frame collision classifier: counts Bumpy/brick overlaps and touched sprite edges,
// then commits a stable result at each frame start for the motion stage.
module bumpy_hit_detect #(
  parameter int OBJECT_SIZE    = 32,
  parameter int EDGE_W         = 4,
  parameter int MIN_HIT_PIXELS = 2,
  parameter int CNT_BITS       = 8
) (
  input  logic               clk,
  input  logic               reset,
  bumpy_hit_detect_if.slave  hit_if
);

  typedef enum logic {WAIT_FRAME = 1'b0, ACCUM = 1'b1} state_e;

  localparam logic [10:0]         SIZE_LIM = 11'(OBJECT_SIZE);
  localparam logic [10:0]         EDGE_LO  = 11'(OBJECT_SIZE - EDGE_W);
  localparam logic [10:0]         EDGE_HI  = 11'(EDGE_W);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] MIN_HIT  = CNT_BITS'(MIN_HIT_PIXELS);

  state_e state_q, state_d;

  logic signed [11:0] off_x_d, off_y_d, off_x_q, off_y_q;
  logic bumpy_q, solid_q, jump_q, sof_d1_q, sof_d2_q;
  logic hit_s_q, hit_j_q;
  logic in_range;
  logic [3:0] e_d, e_q;

  logic [CNT_BITS-1:0] cnt_s_q, cnt_s_d, cnt_j_q, cnt_j_d;
  logic [3:0] edge_acc_q, edge_acc_d;
  logic commit;

  logic collision_q, jump_collision_q;
  logic [3:0] hit_edge_q;

  // topLeft may be negative when Bumpy is partly off-screen, so offsets are 12-bit signed
  assign off_x_d = {1'b0, hit_if.pixelX} - {hit_if.topLeftX[10], hit_if.topLeftX};
  assign off_y_d = {1'b0, hit_if.pixelY} - {hit_if.topLeftY[10], hit_if.topLeftY};

  always_comb begin
    in_range = !off_x_q[11] && !off_y_q[11] &&
               (off_x_q[10:0] < SIZE_LIM) && (off_y_q[10:0] < SIZE_LIM);
    e_d      = '0;
    if (in_range) begin
      e_d[0] = off_y_q[10:0] >= EDGE_LO;
      e_d[1] = off_x_q[10:0] >= EDGE_LO;
      e_d[2] = off_y_q[10:0] <  EDGE_HI;
      e_d[3] = off_x_q[10:0] <  EDGE_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_x_q  <= '0;
      off_y_q  <= '0;
      sof_d1_q <= 1'b0;
      sof_d2_q <= 1'b0;
      e_q      <= '0;
      bumpy_q  <= 1'b0;
      solid_q  <= 1'b0;
      jump_q   <= 1'b0;
      hit_s_q  <= 1'b0;
      hit_j_q  <= 1'b0;
    end else begin
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      sof_d1_q <= hit_if.startOfFrame;
      sof_d2_q <= sof_d1_q;
      e_q      <= e_d;
      if (hit_if.EndGame) begin
        bumpy_q <= 1'b0;
        solid_q <= 1'b0;
        jump_q  <= 1'b0;
        hit_s_q <= 1'b0;
        hit_j_q <= 1'b0;
      end else begin
        bumpy_q <= hit_if.bumpyDR;
        solid_q <= hit_if.brickDR | hit_if.borderDR;
        jump_q  <= hit_if.jumpBrickDR;
        hit_s_q <= bumpy_q & solid_q;
        hit_j_q <= bumpy_q & jump_q;
      end
    end
  end

  // The sof_d2 cycle's own pixel opens the new frame, hence reload rather than clear
  always_comb begin
    cnt_s_d    = cnt_s_q;
    cnt_j_d    = cnt_j_q;
    edge_acc_d = edge_acc_q;
    if (hit_if.EndGame) begin
      cnt_s_d    = '0;
      cnt_j_d    = '0;
      edge_acc_d = '0;
    end else if (sof_d2_q) begin
      cnt_s_d    = CNT_BITS'(hit_s_q);
      cnt_j_d    = CNT_BITS'(hit_j_q);
      edge_acc_d = (hit_s_q | hit_j_q) ? e_q : 4'b0000;
    end else begin
      if (hit_s_q && (cnt_s_q != CNT_MAX)) cnt_s_d = cnt_s_q + 1'b1;
      if (hit_j_q && (cnt_j_q != CNT_MAX)) cnt_j_d = cnt_j_q + 1'b1;
      if (hit_s_q | hit_j_q) edge_acc_d = edge_acc_q | e_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_FRAME;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (hit_if.EndGame)  state_d = WAIT_FRAME;
    else if (sof_d2_q)   state_d = ACCUM;
  end

  always_comb begin
    commit = (state_q == ACCUM) && sof_d2_q && !hit_if.EndGame;
  end

  always_ff @(posedge clk) begin
    if (reset || hit_if.EndGame) begin
      cnt_s_q          <= '0;
      cnt_j_q          <= '0;
      edge_acc_q       <= '0;
      collision_q      <= 1'b0;
      jump_collision_q <= 1'b0;
      hit_edge_q       <= '0;
    end else begin
      cnt_s_q    <= cnt_s_d;
      cnt_j_q    <= cnt_j_d;
      edge_acc_q <= edge_acc_d;
      if (commit) begin
        collision_q      <= cnt_s_q >= MIN_HIT;
        jump_collision_q <= cnt_j_q >= MIN_HIT;
        hit_edge_q       <= ((cnt_s_q >= MIN_HIT) || (cnt_j_q >= MIN_HIT)) ? edge_acc_q : 4'b0000;
      end
    end
  end

  assign hit_if.collision     = collision_q;
  assign hit_if.jumpCollision = jump_collision_q;
  assign hit_if.HitEdgeCode   = hit_edge_q;

endmodule

// File: tb/tb_bumpy_hit_detect.sv
// Scoreboard bench for bumpy_hit_detect: a frame-level model predicts each commit when
// startOfFrame is driven, and the prediction is compared two cycles later.
module tb_bumpy_hit_detect;
  localparam int OBJ = 32;
  localparam int EW  = 4;
  localparam int MIN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bumpy_hit_detect_if hit_if ();
  bumpy_hit_detect dut (.clk(clk), .reset(reset), .hit_if(hit_if));

  int n_total = 0;
  int n_pass  = 0;
  int cur_tlx = 0;
  int cur_tly = 0;

  bit       m_state = 1'b0;
  int       m_cs = 0;
  int       m_cj = 0;
  logic [3:0] m_acc = '0;
  logic [5:0] m_out = '0;
  logic [5:0] sb_q [$];
  logic [5:0] exp_v, prev_v, obs_v;

  function automatic logic [3:0] edge_of(input int x, input int y);
    int ox, oy;
    logic [3:0] ev;
    ox = x - cur_tlx;
    oy = y - cur_tly;
    ev = '0;
    if (ox >= 0 && ox < OBJ && oy >= 0 && oy < OBJ) begin
      ev[0] = oy >= OBJ - EW;
      ev[1] = ox >= OBJ - EW;
      ev[2] = oy < EW;
      ev[3] = ox < EW;
    end
    return ev;
  endfunction

  task automatic drive(input int x, input int y, input bit bumpy, input bit brick,
                       input bit jump, input bit border, input bit sof, input bit eg);
    bit hs, hj, c, j;
    hs = bumpy & (brick | border);
    hj = bumpy & jump;
    if (eg) begin
      m_state = 1'b0; m_cs = 0; m_cj = 0; m_acc = '0; m_out = '0;
      sb_q.delete();
    end else begin
      if (sof) begin
        if (m_state) begin
          c = m_cs >= MIN;
          j = m_cj >= MIN;
          m_out = {c, j, (c | j) ? m_acc : 4'b0000};
        end
        sb_q.push_back(m_out);
        m_state = 1'b1; m_cs = 0; m_cj = 0; m_acc = '0;
      end
      if (hs) m_cs++;
      if (hj) m_cj++;
      if (hs | hj) m_acc |= edge_of(x, y);
    end
    hit_if.pixelX       = 11'(x);
    hit_if.pixelY       = 11'(y);
    hit_if.topLeftX     = 11'(cur_tlx);
    hit_if.topLeftY     = 11'(cur_tly);
    hit_if.bumpyDR      = bumpy;
    hit_if.brickDR      = brick;
    hit_if.jumpBrickDR  = jump;
    hit_if.borderDR     = border;
    hit_if.startOfFrame = sof;
    hit_if.EndGame      = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [5:0] observed();
    return {hit_if.collision, hit_if.jumpCollision, hit_if.HitEdgeCode};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    n_total++;
    if (hit_if.collision !== 1'b0) $display("FAIL reset_collision got %b want 0", hit_if.collision);
    else n_pass++;
    n_total++;
    if (hit_if.jumpCollision !== 1'b0) $display("FAIL reset_jump got %b want 0", hit_if.jumpCollision);
    else n_pass++;
    n_total++;
    if (hit_if.HitEdgeCode !== 4'b0000) $display("FAIL reset_edge got %b want 0000", hit_if.HitEdgeCode);
    else n_pass++;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_bottom_hit();
    cur_tlx = 104; cur_tly = 428;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL first_sof_hold scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL first_sof_hold got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
    for (int y = 458; y <= 459; y++)
      for (int x = 110; x <= 113; x++) drive(x, y, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL bottom_hit scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL bottom_hit got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_threshold();
    cur_tlx = 200; cur_tly = 100;
    drive(200, 115, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL threshold_one scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL threshold_one got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
    drive(200, 115, 1, 1, 0, 0, 0, 0);
    drive(201, 115, 1, 0, 0, 1, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL threshold_two scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL threshold_two got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_jump_corner();
    cur_tlx = 300; cur_tly = 200;
    drive(331, 200, 1, 0, 1, 0, 0, 0);
    drive(330, 201, 1, 0, 1, 0, 0, 0);
    drive(333, 210, 0, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL jump_corner scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL jump_corner got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_frame_boundary();
    cur_tlx = 300; cur_tly = 200;
    drive(310, 210, 1, 1, 0, 0, 0, 0);
    idle(1);
    prev_v = m_out;
    drive(311, 210, 1, 1, 0, 0, 1, 0);
    idle(1);
    n_total++;
    obs_v = observed();
    if (obs_v !== prev_v) $display("FAIL boundary_hold got %b want %b", obs_v, prev_v);
    else n_pass++;
    idle(1);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL boundary_commit scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL boundary_commit got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
    drive(312, 210, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL boundary_carry scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL boundary_carry got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_endgame();
    cur_tlx = 400; cur_tly = 300;
    for (int x = 401; x <= 403; x++) drive(x, 310, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL eg_frame1 scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL eg_frame1 got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
    drive(405, 310, 1, 1, 0, 0, 0, 0);
    drive(406, 310, 1, 1, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    n_total++;
    obs_v = observed();
    if (obs_v !== 6'b0) $display("FAIL eg_clear got %b want 000000", obs_v);
    else n_pass++;
    drive(407, 310, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL eg_suppressed scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL eg_suppressed got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
    drive(431, 331, 1, 1, 0, 0, 0, 0);
    drive(430, 331, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL eg_full_frame scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL eg_full_frame got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_endgame_coincident();
    cur_tlx = 400; cur_tly = 300;
    drive(410, 310, 1, 1, 0, 0, 0, 0);
    drive(411, 310, 1, 1, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    n_total++;
    obs_v = observed();
    if (obs_v !== 6'b0) $display("FAIL coincident_clear got %b want 000000", obs_v);
    else n_pass++;
    idle(1);
    drive(412, 310, 1, 1, 0, 0, 0, 0);
    drive(413, 310, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL coincident_wait scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL coincident_wait got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    cur_tlx = 0; cur_tly = 0;
    for (int i = 0; i < 300; i++) drive(10, 10, 1, 1, 0, 0, 0, 0);
    idle(2);
    n_total++;
    if (dut.cnt_s_q !== 8'd255) $display("FAIL sat_counter got %0d want 255", dut.cnt_s_q);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    n_total++;
    if (sb_q.size() == 0) $display("FAIL sat_commit scoreboard empty");
    else begin
      exp_v = sb_q.pop_front(); obs_v = observed();
      if (obs_v !== exp_v) $display("FAIL sat_commit got %b want %b", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    hit_if.startOfFrame = 1'b0;
    hit_if.pixelX = '0; hit_if.pixelY = '0;
    hit_if.topLeftX = '0; hit_if.topLeftY = '0;
    hit_if.bumpyDR = 1'b0; hit_if.brickDR = 1'b0;
    hit_if.jumpBrickDR = 1'b0; hit_if.borderDR = 1'b0;
    hit_if.EndGame = 1'b0;
    test_reset();
    test_bottom_hit();
    test_threshold();
    test_jump_corner();
    test_frame_boundary();
    test_endgame();
    test_endgame_coincident();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
